mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares one single-port memory between the CPU's instruction-fetch port and its load/store port. Sequences each access as a request/ack transaction to the memory, gives load/store priority, and bounds fetch starvation with a streak counter. Sits between the 5-stage core's fetch stage (PC address in, instruction out) and memory stage (lw/sw enables, address, store data), and the shared instruction/data memory.

## Interface
Parameters:
- AW, 32, address width
- DW, 32, data width
- MAX_STREAK, 4, consecutive data grants allowed while a fetch is pending (≥1)
- TIMEOUT, 64, watchdog limit in cycles (used only with the watchdog feature)

Ports:
- clk  in  1  sole clock, rising edge
- rst  in  1  asynchronous, active-high reset
- if_req  in  1  fetch request, held until if_ack
- if_addr  in  AW  fetch address, stable while if_req
- if_rdata  out  DW  fetched instruction, valid with if_ack
- if_ack  out  1  one-cycle fetch completion pulse
- d_req  in  1  load/store request, held until d_ack
- d_we  in  1  1 = store (sw), 0 = load (lw)
- d_addr  in  AW  data address
- d_wdata  in  DW  store data
- d_rdata  out  DW  load data, valid with d_ack
- d_ack  out  1  one-cycle data completion pulse
- mem_req  out  1  memory request, held until mem_ack
- mem_we  out  1  memory write enable
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data, valid with mem_ack
- mem_ack  in  1  memory completion, any latency ≥0 cycles after mem_req rises
- if_err, d_err  out  1 each  timeout error pulses (only with ARB_TIMEOUT_EN; otherwise tied 0)

## Operation
- FSM states: IDLE, BUSY_I, BUSY_D, RESP.
- IDLE: if d_req and (streak < MAX_STREAK or !if_req) → BUSY_D; else if if_req → BUSY_I; else stay. Requests sampled only in IDLE.
- On grant: mem_addr/mem_we/mem_wdata registered from the winner; mem_we forced 0 for fetch; mem_req=1 from the next cycle.
- BUSY_x: hold mem_req and all mem_* stable until mem_ack sampled 1; then capture mem_rdata into the winner's rdata register, → RESP.
- RESP: winner's ack high for exactly this cycle, mem_req=0, → IDLE. Requester must drop req before the next IDLE sample, or it is taken as a new request.
- Streak counter (width clog2(MAX_STREAK+1)): +1 on a data grant while if_req=1; cleared on a fetch grant or a data grant with if_req=0; saturates at MAX_STREAK.
- if_rdata/d_rdata hold their last value between acks; d_rdata is not updated for stores.
- mem_ack outside BUSY_x is ignored.

## Timing
- Reset values: state IDLE, mem_req 0, mem_we 0, mem_addr 0, mem_wdata 0, if_rdata 0, d_rdata 0, if_ack 0, d_ack 0, err 0, streak 0.
- Request sampled at edge N → mem_req high in cycle N+1; mem_ack in cycle M (M ≥ N+1) → ack in cycle M+1 → IDLE in M+2.
- Minimum transaction: 3 cycles grant-to-next-sample (zero-wait memory acks in N+1).
- Simultaneous if_req/d_req: data wins unless streak = MAX_STREAK.
- Reset mid-transaction: async abort, all outputs to reset values immediately; no ack issued for the aborted access.

## Configuration
- ARB_TIMEOUT_EN defined: watchdog counts cycles in BUSY_x; when it reaches TIMEOUT without mem_ack, drop mem_req, pulse if_err or d_err (with the matching ack) in RESP, rdata unchanged. Counter cleared on entry to BUSY_x.
- Undefined: no counter; BUSY_x waits indefinitely; if_err and d_err constant 0.

## Structure
- Shared package: state enum encoding (IDLE=0, BUSY_I=1, BUSY_D=2, RESP=3), grant-owner constants (OWN_I, OWN_D), default MAX_STREAK and TIMEOUT.
- One sub-module: arb_watchdog (load/clear, count, expiry flag), instantiated only under ARB_TIMEOUT_EN.

## Test plan
- Fetch only: if_req, if_addr=0x0000_0010, memory acks 2 cycles later with 0x0000_0093 → mem_we=0, mem_addr=0x10, if_ack one cycle, if_rdata=0x93.
- Store: d_req, d_we=1, d_addr=0x100, d_wdata=0xDEADBEEF, zero-wait ack → mem_we=1, mem_wdata=0xDEADBEEF, d_ack in cycle N+2, d_rdata unchanged.
- Simultaneous requests with MAX_STREAK=4: both asserted continuously → grant order D,D,D,D,I,D,D,D,D,I.
- Back-to-back: requester keeps d_req held past d_ack → second data transaction starts at next IDLE sample, exactly one ack per transaction.
- Reset asserted during BUSY_D with mem_ack pending → mem_req, d_ack 0 immediately; after release, state IDLE and streak 0.
- ARB_TIMEOUT_EN, TIMEOUT=8, memory never acks fetch → mem_req drops after 8 BUSY_I cycles, if_err and if_ack pulse together; without the macro mem_req stays high.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared state encoding, grant owners and default limits
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2,
    RESP   = 2'd3
  } arb_state_e;

  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  localparam int DEF_MAX_STREAK = 4;
  localparam int DEF_TIMEOUT    = 64;

endpackage

// File: rtl/arb_watchdog.sv
// rtl/arb_watchdog.sv - busy-cycle watchdog; used by mem_port_arbiter only when ARB_TIMEOUT_EN is defined
module arb_watchdog #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic count_en_i,
  output logic expired_o
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // The cycle that flags expiry is itself the TIMEOUT-th busy cycle.
  assign expired_o = count_en_i && (cnt_q == CW'(TIMEOUT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (count_en_i && !expired_o) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fetch vs load/store arbiter for one shared memory port
// Optional watchdog abort of stalled memory accesses: define ARB_TIMEOUT_EN.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int MAX_STREAK = DEF_MAX_STREAK,
  parameter int TIMEOUT    = DEF_TIMEOUT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_ack,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_ack,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack,
  output logic          if_err,
  output logic          d_err
);

  localparam int SW = $clog2(MAX_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_STREAK);

  arb_state_e    state_q;
  logic          owner_q;
  logic [SW-1:0] streak_q;
  logic          mem_req_q, mem_we_q;
  logic [AW-1:0] mem_addr_q;
  logic [DW-1:0] mem_wdata_q;
  logic [DW-1:0] if_rdata_q, d_rdata_q;
  logic          if_ack_q, d_ack_q, if_err_q, d_err_q;
  logic          busy, wd_expired, data_wins;

  assign busy      = (state_q == BUSY_I) || (state_q == BUSY_D);
  assign data_wins = d_req && (!if_req || (streak_q < STREAK_MAX));

`ifdef ARB_TIMEOUT_EN
  arb_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .clk        (clk),
    .rst        (rst),
    .clear_i    (state_q == IDLE),
    .count_en_i (busy),
    .expired_o  (wd_expired)
  );
`else
  // No watchdog: a stalled access waits forever.
  assign wd_expired = 1'b0 & (TIMEOUT < 1);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      owner_q     <= OWN_I;
      streak_q    <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      if_ack_q    <= 1'b0;
      d_ack_q     <= 1'b0;
      if_err_q    <= 1'b0;
      d_err_q     <= 1'b0;
    end else begin
      if_ack_q <= 1'b0;
      d_ack_q  <= 1'b0;
      if_err_q <= 1'b0;
      d_err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (data_wins) begin
            state_q     <= BUSY_D;
            owner_q     <= OWN_D;
            mem_req_q   <= 1'b1;
            mem_we_q    <= d_we;
            mem_addr_q  <= d_addr;
            mem_wdata_q <= d_wdata;
            // data_wins guarantees the streak is below the limit when if_req is high
            streak_q    <= if_req ? streak_q + SW'(1) : '0;
          end else if (if_req) begin
            state_q     <= BUSY_I;
            owner_q     <= OWN_I;
            mem_req_q   <= 1'b1;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= if_addr;
            mem_wdata_q <= '0;
            streak_q    <= '0;
          end
        end
        BUSY_I, BUSY_D: begin
          if (mem_ack || wd_expired) begin
            state_q   <= RESP;
            mem_req_q <= 1'b0;
            if (owner_q == OWN_D) begin
              d_ack_q <= 1'b1;
              d_err_q <= !mem_ack;
              if (mem_ack && !mem_we_q) begin
                d_rdata_q <= mem_rdata;
              end
            end else begin
              if_ack_q <= 1'b1;
              if_err_q <= !mem_ack;
              if (mem_ack) begin
                if_rdata_q <= mem_rdata;
              end
            end
          end
        end
        RESP: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign if_ack    = if_ack_q;
  assign d_ack     = d_ack_q;
  assign if_err    = if_err_q;
  assign d_err     = d_err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, d_req, d_we, mem_ack;
  logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
  logic        if_ack, d_ack, mem_req, mem_we, if_err, d_err;

  int passed = 0;
  int total  = 0;

  mem_port_arbiter #(
    .AW(32), .DW(32), .MAX_STREAK(4), .TIMEOUT(8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_rdata  (if_rdata),
    .if_ack    (if_ack),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_rdata   (d_rdata),
    .d_ack     (d_ack),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .if_err    (if_err),
    .d_err     (d_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for mem_req, then acks it with zero wait; returns in the RESP cycle.
  task automatic serve_one(input logic [31:0] rdata, output logic [31:0] addr, output bit found);
    found = 1'b0;
    addr  = '0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (mem_req) begin
        found = 1'b1;
        break;
      end
    end
    if (found) begin
      addr      = mem_addr;
      mem_rdata = rdata;
      mem_ack   = 1'b1;
      tick();
      mem_ack   = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    total++; if (mem_req !== 1'b0) $display("FAIL reset_mem_req got %0h want 0", mem_req); else passed++;
    total++; if (mem_we !== 1'b0) $display("FAIL reset_mem_we got %0h want 0", mem_we); else passed++;
    total++; if (mem_addr !== 32'h0) $display("FAIL reset_mem_addr got %0h want 0", mem_addr); else passed++;
    total++; if (mem_wdata !== 32'h0) $display("FAIL reset_mem_wdata got %0h want 0", mem_wdata); else passed++;
    total++; if (if_rdata !== 32'h0) $display("FAIL reset_if_rdata got %0h want 0", if_rdata); else passed++;
    total++; if (d_rdata !== 32'h0) $display("FAIL reset_d_rdata got %0h want 0", d_rdata); else passed++;
    total++; if ({if_ack, d_ack} !== 2'b00) $display("FAIL reset_acks got %b want 00", {if_ack, d_ack}); else passed++;
    total++; if ({if_err, d_err} !== 2'b00) $display("FAIL reset_errs got %b want 00", {if_err, d_err}); else passed++;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_fetch();
    if_req  = 1'b1;
    if_addr = 32'h0000_0010;
    tick();
    total++; if (mem_req !== 1'b1) $display("FAIL fetch_mem_req got %0h want 1", mem_req); else passed++;
    total++; if (mem_we !== 1'b0) $display("FAIL fetch_mem_we got %0h want 0", mem_we); else passed++;
    total++; if (mem_addr !== 32'h10) $display("FAIL fetch_mem_addr got %0h want 10", mem_addr); else passed++;
    tick();
    total++; if (mem_req !== 1'b1 || if_ack !== 1'b0) $display("FAIL fetch_wait got req=%0h ack=%0h want req=1 ack=0", mem_req, if_ack); else passed++;
    mem_ack   = 1'b1;
    mem_rdata = 32'h0000_0093;
    tick();
    mem_ack   = 1'b0;
    mem_rdata = 32'h0;
    total++; if (if_ack !== 1'b1) $display("FAIL fetch_ack got %0h want 1", if_ack); else passed++;
    total++; if (if_rdata !== 32'h93) $display("FAIL fetch_rdata got %0h want 93", if_rdata); else passed++;
    total++; if (mem_req !== 1'b0 || d_ack !== 1'b0) $display("FAIL fetch_resp got req=%0h d_ack=%0h want 0 0", mem_req, d_ack); else passed++;
    if_req = 1'b0;
    tick();
    total++; if (if_ack !== 1'b0) $display("FAIL fetch_ack_pulse got %0h want 0", if_ack); else passed++;
    total++; if (if_rdata !== 32'h93) $display("FAIL fetch_rdata_hold got %0h want 93", if_rdata); else passed++;
  endtask

  task automatic test_store();
    d_req   = 1'b1;
    d_we    = 1'b1;
    d_addr  = 32'h100;
    d_wdata = 32'hDEAD_BEEF;
    tick();
    total++; if (mem_req !== 1'b1 || mem_we !== 1'b1) $display("FAIL store_req got req=%0h we=%0h want 1 1", mem_req, mem_we); else passed++;
    total++; if (mem_addr !== 32'h100) $display("FAIL store_addr got %0h want 100", mem_addr); else passed++;
    total++; if (mem_wdata !== 32'hDEAD_BEEF) $display("FAIL store_wdata got %0h want deadbeef", mem_wdata); else passed++;
    mem_ack   = 1'b1;
    mem_rdata = 32'hCAFE_F00D;
    tick();
    mem_ack = 1'b0;
    total++; if (d_ack !== 1'b1 || if_ack !== 1'b0) $display("FAIL store_ack got d=%0h i=%0h want 1 0", d_ack, if_ack); else passed++;
    total++; if (d_rdata !== 32'h0) $display("FAIL store_rdata_kept got %0h want 0", d_rdata); else passed++;
    d_req = 1'b0;
    d_we  = 1'b0;
    tick();
    total++; if (d_ack !== 1'b0) $display("FAIL store_ack_pulse got %0h want 0", d_ack); else passed++;
  endtask

  task automatic test_priority();
    bit          exp_d [10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
    logic [31:0] addr;
    bit          found;
    if_req  = 1'b1;
    if_addr = 32'h200;
    d_req   = 1'b1;
    d_we    = 1'b0;
    d_addr  = 32'h300;
    for (int g = 0; g < 10; g++) begin
      serve_one(32'h1000 + g, addr, found);
      total++;
      if (!found) begin
        $display("FAIL prio_grant%0d timeout waiting for mem_req", g);
      end else if ((addr == 32'h300) !== exp_d[g]) begin
        $display("FAIL prio_grant%0d got addr %0h want data=%0d", g, addr, exp_d[g]);
      end else begin
        passed++;
      end
      total++;
      if ({d_ack, if_ack} !== {exp_d[g], !exp_d[g]})
        $display("FAIL prio_ack%0d got d=%0h i=%0h want d=%0d", g, d_ack, if_ack, exp_d[g]);
      else passed++;
    end
    if_req = 1'b0;
    d_req  = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_back_to_back();
    int          acks = 0;
    int          a1 = 0, a2 = 0, n = 0;
    logic [31:0] rd1 = '0;
    d_req  = 1'b1;
    d_we   = 1'b0;
    d_addr = 32'h104;
    for (int c = 1; c <= 20 && acks < 2; c++) begin
      tick();
      mem_ack = 1'b0;
      if (mem_req) begin
        mem_ack   = 1'b1;
        mem_rdata = (n == 0) ? 32'h1111_1111 : 32'h2222_2222;
        n++;
      end
      if (d_ack) begin
        acks++;
        if (acks == 1) begin
          a1  = c;
          rd1 = d_rdata;
        end else begin
          a2 = c;
        end
      end
    end
    d_req   = 1'b0;
    mem_ack = 1'b0;
    total++; if (acks != 2) $display("FAIL b2b_ack_count got %0d want 2", acks); else passed++;
    total++; if (a2 - a1 != 3) $display("FAIL b2b_spacing got %0d want 3", a2 - a1); else passed++;
    total++; if (rd1 !== 32'h1111_1111) $display("FAIL b2b_rdata1 got %0h want 11111111", rd1); else passed++;
    total++; if (d_rdata !== 32'h2222_2222) $display("FAIL b2b_rdata2 got %0h want 22222222", d_rdata); else passed++;
    tick();
    tick();
    total++; if (mem_req !== 1'b0 || d_ack !== 1'b0) $display("FAIL b2b_no_extra got req=%0h ack=%0h want 0 0", mem_req, d_ack); else passed++;
  endtask

  task automatic test_reset_mid();
    logic [31:0] addr;
    bit          found;
    if_req  = 1'b1;
    if_addr = 32'h200;
    d_req   = 1'b1;
    d_we    = 1'b0;
    d_addr  = 32'h300;
    // Three data grants with a fetch pending bring the streak to 3; the fourth is aborted.
    for (int g = 0; g < 3; g++) begin
      serve_one(32'h5000 + g, addr, found);
      total++; if (!found || addr !== 32'h300) $display("FAIL rstmid_grant%0d got addr %0h found %0d want 300", g, addr, found); else passed++;
    end
    found = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      tick();
      found = mem_req;
    end
    total++; if (!found || mem_addr !== 32'h300) $display("FAIL rstmid_busy_d got req=%0h addr=%0h want 1 300", mem_req, mem_addr); else passed++;
    #2;
    rst       = 1'b1;
    mem_ack   = 1'b1;
    mem_rdata = 32'hBAD0_BAD0;
    #1;
    total++; if (mem_req !== 1'b0 || d_ack !== 1'b0) $display("FAIL rstmid_abort got req=%0h ack=%0h want 0 0", mem_req, d_ack); else passed++;
    total++; if (mem_addr !== 32'h0 || d_rdata !== 32'h0) $display("FAIL rstmid_clear got addr=%0h rdata=%0h want 0 0", mem_addr, d_rdata); else passed++;
    tick();
    tick();
    total++; if (d_ack !== 1'b0) $display("FAIL rstmid_no_ack got %0h want 0", d_ack); else passed++;
    rst     = 1'b0;
    mem_ack = 1'b0;
    // Cleared streak means data wins again even though a fetch is pending.
    serve_one(32'h6000, addr, found);
    total++; if (!found || addr !== 32'h300) $display("FAIL rstmid_streak got addr %0h found %0d want 300", addr, found); else passed++;
    total++; if (d_ack !== 1'b1 || d_rdata !== 32'h6000) $display("FAIL rstmid_after got ack=%0h rdata=%0h want 1 6000", d_ack, d_rdata); else passed++;
    if_req = 1'b0;
    d_req  = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_timeout();
    int cnt = 0;
    if_req  = 1'b1;
    if_addr = 32'h80;
    tick();
    while (mem_req && cnt < 20) begin
      cnt++;
      tick();
    end
`ifdef ARB_TIMEOUT_EN
    total++; if (cnt != 8) $display("FAIL timeout_cycles got %0d want 8", cnt); else passed++;
    total++; if ({if_err, if_ack} !== 2'b11) $display("FAIL timeout_err_ack got %b want 11", {if_err, if_ack}); else passed++;
    total++; if (if_rdata !== 32'h0 || d_err !== 1'b0) $display("FAIL timeout_rdata got %0h d_err=%0h want 0 0", if_rdata, d_err); else passed++;
    if_req = 1'b0;
    tick();
    total++; if (if_err !== 1'b0) $display("FAIL timeout_err_pulse got %0h want 0", if_err); else passed++;
`else
    total++; if (cnt != 20 || mem_req !== 1'b1) $display("FAIL no_timeout_hold got cycles=%0d req=%0h want 20 1", cnt, mem_req); else passed++;
    total++; if ({if_err, d_err, if_ack} !== 3'b000) $display("FAIL no_timeout_err got %b want 000", {if_err, d_err, if_ack}); else passed++;
    if_req = 1'b0;
    rst    = 1'b1;
    tick();
    rst    = 1'b0;
    tick();
`endif
  endtask

  initial begin
    rst       = 1'b1;
    if_req    = 1'b0;
    if_addr   = '0;
    d_req     = 1'b0;
    d_we      = 1'b0;
    d_addr    = '0;
    d_wdata   = '0;
    mem_rdata = '0;
    mem_ack   = 1'b0;
    test_reset();
    test_fetch();
    test_store();
    test_priority();
    test_back_to_back();
    test_reset_mid();
    test_timeout();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1);
  end

endmodule
